// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C register target.
// Holds the FSM state encoding and the pointer increment rule.
package i2c_target_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int PTR_W      = 4;
    localparam logic [7:0] RD_OOR = 8'hFF;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_PTR,
        S_PTR_ACK,
        S_WDATA,
        S_WDATA_ACK,
        S_RDATA,
        S_RACK,
        S_WAIT
    } state_t;

    // Wrap at the last register, saturate at 15 once out of range.
    function automatic logic [PTR_W-1:0] ptr_inc(
        input logic [PTR_W-1:0] p,
        input logic [PTR_W:0]   n
    );
        logic [PTR_W:0] pe;
        pe = {1'b0, p};
        if (pe == n - (PTR_W+1)'(1)) return '0;
        if (pe >= n) return '1;
        return p + PTR_W'(1);
    endfunction

endpackage

// File: rtl/i2c_in_filter.sv
// Synchroniser and glitch filter for one bus line.
// Produces a clean level plus single-cycle rise/fall flags.
module i2c_in_filter #(
    parameter int FILT_LEN = 3
) (
    input  logic I_clk,
    input  logic I_rst_n,
    input  logic I_in,
    output logic O_lvl,
    output logic O_rise,
    output logic O_fall
);

    localparam int CW = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN + 1);

    logic          s1, s2;
    logic          lvl_q, lvl_d1;
    logic [CW-1:0] cnt;

    // Two-flop synchroniser; idle bus level is high.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= I_in;
            s2 <= s1;
        end
    end

    // Accept a new level only after FILT_LEN identical samples.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            lvl_q  <= 1'b1;
            lvl_d1 <= 1'b1;
            cnt    <= '0;
        end else begin
            lvl_d1 <= lvl_q;
            if (s2 == lvl_q) begin
                cnt <= '0;
            end else if (cnt == CW'(FILT_LEN - 1)) begin
                lvl_q <= s2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign O_lvl  = lvl_q;
    assign O_rise = lvl_q & ~lvl_d1;
    assign O_fall = ~lvl_q & lvl_d1;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing a small read/write register bank.
// SCL/SDA are oversampled on I_clk; SDA is driven open-drain via O_sda_oe.
module i2c_target_regs
    import i2c_target_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] DEV_ADDR = 7'h3C,
    parameter int                    REG_NUM  = 4,
    parameter int                    FILT_LEN = 3,
    parameter logic [8*REG_NUM-1:0]  RST_VAL  = 32'h0000_0001
) (
    input  logic                 I_clk,
    input  logic                 I_rst_n,
    input  logic                 I_scl,
    input  logic                 I_sda,
    output logic                 O_sda_oe,
    output logic [8*REG_NUM-1:0] O_reg_flat,
    output logic                 O_wr_stb,
    output logic [PTR_W-1:0]     O_wr_addr,
    output logic                 O_busy
);

    localparam logic [PTR_W:0] REG_CNT = (PTR_W+1)'(REG_NUM);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic start, stop;

    i2c_in_filter #(.FILT_LEN(FILT_LEN)) u_scl (
        .I_clk  (I_clk),
        .I_rst_n(I_rst_n),
        .I_in   (I_scl),
        .O_lvl  (scl_lvl),
        .O_rise (scl_rise),
        .O_fall (scl_fall)
    );

    i2c_in_filter #(.FILT_LEN(FILT_LEN)) u_sda (
        .I_clk  (I_clk),
        .I_rst_n(I_rst_n),
        .I_in   (I_sda),
        .O_lvl  (sda_lvl),
        .O_rise (sda_rise),
        .O_fall (sda_fall)
    );

    assign start = sda_fall & scl_lvl;
    assign stop  = sda_rise & scl_lvl;

    state_t           state_q, state_d;
    logic [2:0]       bit_q, bit_d;
    logic [6:0]       sh_q, sh_d;
    logic [6:0]       tx_q, tx_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] waddr_q, waddr_d;
    logic             rw_q, rw_d;
    logic             oe_q, oe_d;
    logic             busy_q, busy_d;
    logic             stb_q, stb_d;
    logic             pend_q, pend_d;
    logic             we;
    logic             in_range;
    logic [7:0]       rx_byte;
    logic [7:0]       rd_byte;
    logic [7:0]       regs_q [REG_NUM];

    assign rx_byte  = {sh_q, sda_lvl};
    assign in_range = {1'b0, ptr_q} < REG_CNT;

    // Read mux; unmapped pointer values read as all ones.
    always_comb begin
        rd_byte = RD_OOR;
        for (int i = 0; i < REG_NUM; i++) begin
            if (ptr_q == PTR_W'(i)) rd_byte = regs_q[i];
        end
    end

    // Protocol state and bit-level datapath registers.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q <= S_IDLE;
            bit_q   <= '0;
            sh_q    <= '0;
            tx_q    <= '0;
            ptr_q   <= '0;
            waddr_q <= '0;
            rw_q    <= 1'b0;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            stb_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
            ptr_q   <= ptr_d;
            waddr_q <= waddr_d;
            rw_q    <= rw_d;
            oe_q    <= oe_d;
            busy_q  <= busy_d;
            stb_q   <= stb_d;
            pend_q  <= pend_d;
        end
    end

    // Next-state logic; START/STOP override every state.
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        tx_d    = tx_q;
        ptr_d   = ptr_q;
        waddr_d = waddr_q;
        rw_d    = rw_q;
        oe_d    = oe_q;
        busy_d  = busy_q;
        pend_d  = pend_q;
        stb_d   = 1'b0;
        we      = 1'b0;
        if (start) begin
            state_d = S_ADDR;
            bit_d   = '0;
            sh_d    = '0;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
            pend_d  = 1'b0;
        end else if (stop) begin
            state_d = S_IDLE;
            bit_d   = '0;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
            pend_d  = 1'b0;
        end else begin
            unique case (state_q)
                S_ADDR: begin
                    if (scl_rise) begin
                        sh_d  = rx_byte[6:0];
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            if (rx_byte[7:1] == DEV_ADDR) begin
                                state_d = S_ADDR_ACK;
                                busy_d  = 1'b1;
                                rw_d    = rx_byte[0];
                            end else begin
                                state_d = S_WAIT;
                            end
                        end
                    end
                end
                S_PTR: begin
                    if (scl_rise) begin
                        sh_d  = rx_byte[6:0];
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            ptr_d   = rx_byte[PTR_W-1:0];
                            state_d = S_PTR_ACK;
                        end
                    end
                end
                S_WDATA: begin
                    if (scl_rise) begin
                        sh_d  = rx_byte[6:0];
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            if (in_range) begin
                                we      = 1'b1;
                                stb_d   = 1'b1;
                                waddr_d = ptr_q;
                            end
                            ptr_d   = ptr_inc(ptr_q, REG_CNT);
                            state_d = S_WDATA_ACK;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!oe_q) begin
                            oe_d = 1'b1;
                        end else if (rw_q) begin
                            tx_d    = rd_byte[6:0];
                            oe_d    = ~rd_byte[7];
                            bit_d   = '0;
                            state_d = S_RDATA;
                        end else begin
                            oe_d    = 1'b0;
                            bit_d   = '0;
                            state_d = S_PTR;
                        end
                    end
                end
                S_PTR_ACK, S_WDATA_ACK: begin
                    if (scl_fall) begin
                        if (!oe_q) begin
                            oe_d = 1'b1;
                        end else begin
                            oe_d    = 1'b0;
                            bit_d   = '0;
                            state_d = S_WDATA;
                        end
                    end
                end
                S_RDATA: begin
                    if (scl_fall) begin
                        if (pend_q) begin
                            pend_d = 1'b0;
                            tx_d   = rd_byte[6:0];
                            oe_d   = ~rd_byte[7];
                            bit_d  = '0;
                        end else if (bit_q == 3'd7) begin
                            oe_d    = 1'b0;
                            state_d = S_RACK;
                        end else begin
                            tx_d  = {tx_q[5:0], 1'b0};
                            oe_d  = ~tx_q[6];
                            bit_d = bit_q + 3'd1;
                        end
                    end
                end
                S_RACK: begin
                    if (scl_rise) begin
                        if (!sda_lvl) begin
                            ptr_d   = ptr_inc(ptr_q, REG_CNT);
                            pend_d  = 1'b1;
                            state_d = S_RDATA;
                        end else begin
                            state_d = S_WAIT;
                        end
                    end
                end
                S_IDLE, S_WAIT: begin
                    state_d = state_q;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Register bank, written from the completed data byte.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs_q[i] <= RST_VAL[8*i +: 8];
            end
        end else if (we) begin
            for (int i = 0; i < REG_NUM; i++) begin
                if (ptr_q == PTR_W'(i)) regs_q[i] <= rx_byte;
            end
        end
    end

    // Flatten the bank onto the output bus.
    always_comb begin
        O_reg_flat = '0;
        for (int i = 0; i < REG_NUM; i++) begin
            O_reg_flat[8*i +: 8] = regs_q[i];
        end
    end

    assign O_sda_oe  = oe_q;
    assign O_wr_stb  = stb_q;
    assign O_wr_addr = waddr_q;
    assign O_busy    = busy_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: a bit-banged host drives the bus,
// expected ACK/read bytes and write strobes go through scoreboards.
module tb_i2c_target_regs;

    localparam int Q = 12;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        scl = 1'b1;
    logic        sda_h = 1'b1;
    logic        sda_bus;
    logic        oe;
    logic [31:0] regs;
    logic        stb;
    logic [3:0]  waddr;
    logic        busy;

    typedef struct {
        int         tag;
        logic [7:0] v;
    } item_t;

    item_t       exp_rx[$];
    item_t       act_rx[$];
    logic [11:0] exp_wr[$];

    int          checks = 0;
    int          errors = 0;
    int          oe_hits = 0;
    logic        forbid = 1'b0;
    logic [31:0] model;
    logic [7:0]  rb;

    assign sda_bus = sda_h & ~oe;

    always #10 clk = ~clk;

    i2c_target_regs dut (
        .I_clk     (clk),
        .I_rst_n   (rst_n),
        .I_scl     (scl),
        .I_sda     (sda_bus),
        .O_sda_oe  (oe),
        .O_reg_flat(regs),
        .O_wr_stb  (stb),
        .O_wr_addr (waddr),
        .O_busy    (busy)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    // Write-strobe monitor: each strobe pops one expected {addr,data}.
    always @(negedge clk) begin
        logic [11:0] e;
        logic [11:0] g;
        if (rst_n && stb) begin
            g = {waddr, regs[8*int'(waddr) +: 8]};
            checks++;
            if (exp_wr.size() == 0) begin
                errors++;
                $display("FAIL wr_stb unexpected got=%h", g);
            end else begin
                e = exp_wr.pop_front();
                if (g !== e) begin
                    errors++;
                    $display("FAIL wr_stb got=%h exp=%h", g, e);
                end
            end
        end
        if (forbid && oe) oe_hits++;
    end

    // Bus-response monitor: pairs host-captured slots with expectations.
    always @(negedge clk) begin
        item_t a;
        item_t e;
        while (act_rx.size() > 0) begin
            a = act_rx.pop_front();
            checks++;
            if (exp_rx.size() == 0) begin
                errors++;
                $display("FAIL rx unexpected tag=%0d got=%h", a.tag, a.v);
            end else begin
                e = exp_rx.pop_front();
                if (a.tag != e.tag || a.v !== e.v) begin
                    errors++;
                    $display("FAIL %s got=%h exp=%h",
                             (e.tag == 0) ? "ack_slot" : "rd_byte", a.v, e.v);
                end
            end
        end
    end

    task automatic put_bit(input logic b, input logic g);
        sda_h = b;
        tick(Q);
        scl = 1'b1;
        tick(Q/2);
        if (g) begin
            sda_h = ~b;
            tick(2);
            sda_h = b;
        end else begin
            tick(2);
        end
        tick(Q + Q/2 - 2);
        scl = 1'b0;
        tick(Q);
    endtask

    task automatic get_bit(output logic b, output logic o);
        sda_h = 1'b1;
        tick(Q);
        scl = 1'b1;
        tick(Q);
        b = sda_bus;
        o = oe;
        tick(Q);
        scl = 1'b0;
        tick(Q);
    endtask

    task automatic wr_byte(input logic [7:0] b, input logic ack,
                           input logic g);
        logic bb;
        logic o;
        for (int i = 7; i >= 0; i--) put_bit(b[i], g && i == 7);
        exp_rx.push_back('{0, {7'd0, ack}});
        get_bit(bb, o);
        act_rx.push_back('{0, {7'd0, o}});
    endtask

    task automatic rd_byte(input logic [7:0] ev, input logic nack);
        logic [7:0] v;
        logic       o;
        exp_rx.push_back('{1, ev});
        for (int i = 7; i >= 0; i--) get_bit(v[i], o);
        act_rx.push_back('{1, v});
        put_bit(nack, 1'b0);
    endtask

    task automatic bus_start();
        sda_h = 1'b1;
        scl = 1'b1;
        tick(Q);
        sda_h = 1'b0;
        tick(Q);
        scl = 1'b0;
        tick(Q);
    endtask

    task automatic bus_rstart();
        sda_h = 1'b1;
        tick(Q);
        scl = 1'b1;
        tick(Q);
        sda_h = 1'b0;
        tick(Q);
        scl = 1'b0;
        tick(Q);
    endtask

    task automatic bus_stop();
        sda_h = 1'b0;
        tick(Q);
        scl = 1'b1;
        tick(Q);
        sda_h = 1'b1;
        tick(2*Q);
    endtask

    initial begin
        model = 32'h0000_0001;
        tick(5);
        rst_n = 1'b1;
        tick(10);
        check("rst_oe", {31'd0, oe}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_stb", {31'd0, stb}, 32'd0);
        check("rst_waddr", {28'd0, waddr}, 32'd0);
        check("rst_regs", regs, model);

        // Single write: reg1 <= A5
        bus_start();
        wr_byte(8'h78, 1'b1, 1'b0);
        check("t1_busy", {31'd0, busy}, 32'd1);
        wr_byte(8'h01, 1'b1, 1'b0);
        exp_wr.push_back({4'd1, 8'hA5});
        wr_byte(8'hA5, 1'b1, 1'b0);
        bus_stop();
        model = 32'h0000_A501;
        check("t1_regs", regs, model);
        check("t1_busy_stop", {31'd0, busy}, 32'd0);

        // Burst write wraps from reg3 to reg0
        bus_start();
        wr_byte(8'h78, 1'b1, 1'b0);
        wr_byte(8'h03, 1'b1, 1'b0);
        exp_wr.push_back({4'd3, 8'h11});
        wr_byte(8'h11, 1'b1, 1'b0);
        exp_wr.push_back({4'd0, 8'h22});
        wr_byte(8'h22, 1'b1, 1'b0);
        bus_stop();
        model = 32'h1100_A522;
        check("t2_regs", regs, model);

        // Load 01,A5,5A,11 then read from ptr 2 with repeated start
        bus_start();
        wr_byte(8'h78, 1'b1, 1'b0);
        wr_byte(8'h02, 1'b1, 1'b0);
        exp_wr.push_back({4'd2, 8'h5A});
        wr_byte(8'h5A, 1'b1, 1'b0);
        exp_wr.push_back({4'd3, 8'h11});
        wr_byte(8'h11, 1'b1, 1'b0);
        exp_wr.push_back({4'd0, 8'h01});
        wr_byte(8'h01, 1'b1, 1'b0);
        bus_stop();
        model = 32'h115A_A501;
        check("t3_regs", regs, model);
        bus_start();
        wr_byte(8'h78, 1'b1, 1'b0);
        wr_byte(8'h02, 1'b1, 1'b0);
        bus_rstart();
        wr_byte(8'h79, 1'b1, 1'b0);
        rd_byte(8'h5A, 1'b0);
        rd_byte(8'h11, 1'b0);
        rd_byte(8'h01, 1'b1);
        tick(Q);
        check("t3_oe_nack", {31'd0, oe}, 32'd0);
        check("t3_busy", {31'd0, busy}, 32'd1);
        bus_stop();

        // Foreign address: target must stay silent
        forbid = 1'b1;
        bus_start();
        wr_byte(8'h7A, 1'b0, 1'b0);
        check("t4_busy", {31'd0, busy}, 32'd0);
        wr_byte(8'h00, 1'b0, 1'b0);
        wr_byte(8'h99, 1'b0, 1'b0);
        bus_stop();
        forbid = 1'b0;
        check("t4_oe_hits", oe_hits, 32'd0);
        check("t4_regs", regs, model);

        // Out-of-range pointer: write dropped, read gives FF
        bus_start();
        wr_byte(8'h78, 1'b1, 1'b0);
        wr_byte(8'h09, 1'b1, 1'b0);
        wr_byte(8'h77, 1'b1, 1'b0);
        bus_rstart();
        wr_byte(8'h79, 1'b1, 1'b0);
        rd_byte(8'hFF, 1'b1);
        bus_stop();
        check("t5_regs", regs, model);

        // 2-cycle SDA glitches while SCL high are not START/STOP
        bus_start();
        wr_byte(8'h78, 1'b1, 1'b0);
        wr_byte(8'h80, 1'b1, 1'b1);
        check("t6_busy_glitch", {31'd0, busy}, 32'd1);
        exp_wr.push_back({4'd0, 8'h3C});
        wr_byte(8'h3C, 1'b1, 1'b1);
        bus_stop();
        model = 32'h115A_A53C;
        check("t6_regs_glitch", regs, model);

        // STOP after 4 data bits discards the partial byte
        bus_start();
        wr_byte(8'h78, 1'b1, 1'b0);
        wr_byte(8'h01, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) put_bit(1'b1, 1'b0);
        bus_stop();
        check("t6_regs_partial", regs, model);
        check("t6_busy_partial", {31'd0, busy}, 32'd0);

        // Reset in the middle of a read
        bus_start();
        wr_byte(8'h78, 1'b1, 1'b0);
        wr_byte(8'h00, 1'b1, 1'b0);
        bus_rstart();
        wr_byte(8'h79, 1'b1, 1'b0);
        check("t6_oe_msb", {31'd0, oe}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_oe_rst", {31'd0, oe}, 32'd0);
        check("t6_regs_rst", regs, 32'h0000_0001);
        check("t6_busy_rst", {31'd0, busy}, 32'd0);
        tick(2);
        scl = 1'b1;
        sda_h = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(20);
        check("t6_oe_after", {31'd0, oe}, 32'd0);

        tick(5);
        check("exp_wr_left", exp_wr.size(), 32'd0);
        check("exp_rx_left", exp_rx.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
